// File: rtl/mips_div_pkg.sv
// Shared types and constants for the MIPS DIV/DIVU unit.
package mips_div_pkg;

   localparam int XLEN_DEF = 32;
   localparam int CNT_W = $clog2(XLEN_DEF);
   localparam logic [XLEN_DEF-1:0] DIV_ZERO_LO = {XLEN_DEF{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } div_state_e;

endpackage

// File: rtl/mips_div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract, pick quotient bit.
import mips_div_pkg::*;

module mips_div_step #(
   parameter int XLEN = XLEN_DEF
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] quo_i,
   input  logic [XLEN-1:0] dsor_i,
   output logic [XLEN-1:0] rem_o,
   output logic [XLEN-1:0] quo_o
);

   logic [XLEN:0]   shifted_s;
   logic [XLEN-1:0] diff_s;

   // Shifted partial remainder keeps its carry bit so the compare never wraps.
   always_comb begin
      shifted_s = {rem_i, quo_i[XLEN-1]};
      diff_s    = shifted_s[XLEN-1:0] - dsor_i;
      if (shifted_s >= {1'b0, dsor_i}) begin
         rem_o = diff_s;
         quo_o = {quo_i[XLEN-2:0], 1'b1};
      end else begin
         rem_o = shifted_s[XLEN-1:0];
         quo_o = {quo_i[XLEN-2:0], 1'b0};
      end
   end

endmodule

// File: rtl/mips_div_unit.sv
// Iterative MIPS DIV/DIVU unit owning HI/LO.
// Build option: MIPS_DIV_ZERO_FLAG_EN adds the div_by_zero output.
import mips_div_pkg::*;

module mips_div_unit #(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            is_signed,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   input  logic            hi_we,
   input  logic            lo_we,
   input  logic [XLEN-1:0] wdata,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] hi,
   output logic [XLEN-1:0] lo
`ifdef MIPS_DIV_ZERO_FLAG_EN
   ,
   output logic            div_by_zero
`endif
);

   localparam int CW = (XLEN == XLEN_DEF) ? CNT_W : $clog2(XLEN);
   localparam logic [XLEN-1:0] ZERO_LO = {XLEN{DIV_ZERO_LO[0]}};
   localparam logic [CW-1:0]   LAST_CNT = CW'(XLEN - 1);

   div_state_e      state_q;
   logic [CW-1:0]   cnt_q;
   logic [XLEN-1:0] rem_q, quo_q, dsor_q, dvd_raw_q;
   logic [XLEN-1:0] hi_q, lo_q;
   logic            qneg_q, rneg_q, zero_q;
   logic            busy_q, done_q, dbz_q;

   logic [XLEN-1:0] dvd_mag_d, dsor_mag_d, quo_fix_d, rem_fix_d;
   logic [XLEN-1:0] step_rem_s, step_quo_s;

   mips_div_step #(.XLEN(XLEN)) u_step (
      .rem_i  (rem_q),
      .quo_i  (quo_q),
      .dsor_i (dsor_q),
      .rem_o  (step_rem_s),
      .quo_o  (step_quo_s)
   );

   // Operand magnitudes at start and sign/zero fix-up of the final result.
   always_comb begin
      dvd_mag_d  = (is_signed && dividend[XLEN-1]) ? -dividend : dividend;
      dsor_mag_d = (is_signed && divisor[XLEN-1])  ? -divisor  : divisor;
      if (zero_q) begin
         quo_fix_d = ZERO_LO;
         rem_fix_d = dvd_raw_q;
      end else begin
         quo_fix_d = qneg_q ? -quo_q : quo_q;
         rem_fix_d = rneg_q ? -rem_q : rem_q;
      end
   end

   // Control FSM, iteration datapath and architectural HI/LO.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dsor_q    <= '0;
         dvd_raw_q <= '0;
         qneg_q    <= 1'b0;
         rneg_q    <= 1'b0;
         zero_q    <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dbz_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (hi_we) begin
                  hi_q <= wdata;
               end
               if (lo_we) begin
                  lo_q <= wdata;
               end
               if (start) begin
                  state_q   <= S_RUN;
                  busy_q    <= 1'b1;
                  cnt_q     <= '0;
                  rem_q     <= '0;
                  quo_q     <= dvd_mag_d;
                  dsor_q    <= dsor_mag_d;
                  dvd_raw_q <= dividend;
                  qneg_q    <= is_signed & (dividend[XLEN-1] ^ divisor[XLEN-1]);
                  rneg_q    <= is_signed & dividend[XLEN-1];
                  zero_q    <= (divisor == '0);
               end
            end
            S_RUN: begin
               rem_q <= step_rem_s;
               quo_q <= step_quo_s;
               cnt_q <= cnt_q + CW'(1);
               if (cnt_q == LAST_CNT) begin
                  state_q <= S_FIX;
               end
            end
            S_FIX: begin
               lo_q    <= quo_fix_d;
               hi_q    <= rem_fix_d;
               dbz_q   <= zero_q;
               done_q  <= 1'b1;
               state_q <= S_DONE;
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

`ifdef MIPS_DIV_ZERO_FLAG_EN
   assign div_by_zero = dbz_q;
`else
   logic unused_dbz_s;
   assign unused_dbz_s = dbz_q;
`endif

endmodule

// File: tb/tb_mips_div_unit.sv
// Scoreboard bench for mips_div_unit: directed divides, MT writes, start-while-busy, reset abort.
module tb_mips_div_unit;

   logic        clk = 1'b0;
   logic        rst, start, is_signed, hi_we, lo_we;
   logic [31:0] dividend, divisor, wdata;
   logic        busy, done;
   logic [31:0] hi, lo;
   logic        dbz_s;

   always #5 clk = ~clk;

   mips_div_unit #(.XLEN(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .is_signed   (is_signed),
      .dividend    (dividend),
      .divisor     (divisor),
      .hi_we       (hi_we),
      .lo_we       (lo_we),
      .wdata       (wdata),
      .busy        (busy),
      .done        (done),
      .hi          (hi),
      .lo          (lo)
`ifdef MIPS_DIV_ZERO_FLAG_EN
      ,
      .div_by_zero (dbz_s)
`endif
   );

`ifndef MIPS_DIV_ZERO_FLAG_EN
   assign dbz_s = 1'b0;
`endif

   typedef struct {
      logic [31:0] lo;
      logic [31:0] hi;
      logic        z;
      int          cyc;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_done: got done=1 expected no result (cycle %0d)", cyc);
         end else begin
            mon_e = exp_q.pop_front();
            chk("result_lo", lo, mon_e.lo);
            chk("result_hi", hi, mon_e.hi);
            chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
`ifdef MIPS_DIV_ZERO_FLAG_EN
            chk("div_by_zero", {31'd0, dbz_s}, {31'd0, mon_e.z});
`endif
         end
      end
   end

   // Called at a negedge: presents a start for one cycle and optionally records the expectation.
   task automatic issue(input logic sg, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] elo, input logic [31:0] ehi, input logic ez,
                        input logic push, input logic lw, input logic [31:0] wd);
      start     = 1'b1;
      is_signed = sg;
      dividend  = a;
      divisor   = b;
      lo_we     = lw;
      wdata     = wd;
      if (push) exp_q.push_back('{lo: elo, hi: ehi, z: ez, cyc: cyc + 34});
      @(negedge clk);
      start = 1'b0;
      lo_we = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         n++;
         @(negedge clk);
      end
      if (n >= 200) begin
         checks++;
         failures++;
         $display("FAIL busy_timeout: got busy stuck for %0d cycles expected release", n);
      end
   endtask

   task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] elo, input logic [31:0] ehi, input logic ez);
      int n;
      issue(sg, a, b, elo, ehi, ez, 1'b1, 1'b0, 32'h0000_0000);
      wait_idle(n);
      chk("busy_len", 32'(n), 32'd34);
   endtask

   int n_s;
   int k_s;

   initial begin
      rst = 1'b1; start = 1'b0; is_signed = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      dividend = 32'd0; divisor = 32'd0; wdata = 32'd0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_busy", {31'd0, busy}, 32'd0);
      chk("reset_done", {31'd0, done}, 32'd0);
      chk("reset_hi", hi, 32'd0);
      chk("reset_lo", lo, 32'd0);

      // MTLO / MTHI in IDLE
      lo_we = 1'b1; wdata = 32'hCAFE_BABE;
      @(negedge clk);
      lo_we = 1'b0;
      chk("mtlo_idle", lo, 32'hCAFE_BABE);
      hi_we = 1'b1; wdata = 32'h1111_2222;
      @(negedge clk);
      hi_we = 1'b0;
      chk("mthi_idle", hi, 32'h1111_2222);

      // MTHI while running is ignored; HI/LO stable during RUN
      issue(1'b0, 32'd23, 32'd5, 32'd4, 32'd3, 1'b0, 1'b1, 1'b0, 32'd0);
      repeat (3) @(negedge clk);
      hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      hi_we = 1'b0;
      chk("mthi_busy_ignored", hi, 32'h1111_2222);
      chk("lo_stable_run", lo, 32'hCAFE_BABE);
      wait_idle(n_s);

      run_div(1'b0, 32'd100, 32'd7, 32'h0000_000E, 32'h0000_0002, 1'b0);
      run_div(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
      run_div(1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'h0000_0002, 1'b0);
      run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000, 1'b0);
      run_div(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
      run_div(1'b1, 32'hFFFF_FF9C, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 1'b1);
      run_div(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
      run_div(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0001, 1'b0);

      // Same-cycle start and MTLO: MTLO lands first, divide result overrides it
      issue(1'b0, 32'hFFFF_FFFF, 32'd3, 32'h5555_5555, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 32'h0BAD_F00D);
      chk("mtlo_with_start", lo, 32'h0BAD_F00D);
      wait_idle(n_s);

      // Start while busy is dropped; start right after done is accepted
      issue(1'b0, 32'd1000, 32'd10, 32'h0000_0064, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 32'd0);
      repeat (4) @(negedge clk);
      issue(1'b0, 32'd7, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      k_s = 0;
      while (done !== 1'b1 && k_s < 100) begin
         k_s++;
         @(negedge clk);
      end
      if (k_s >= 100) begin
         checks++;
         failures++;
         $display("FAIL done_timeout: got no done expected one within 100 cycles");
      end
      @(negedge clk);
      issue(1'b0, 32'd50, 32'd8, 32'h0000_0006, 32'h0000_0002, 1'b0, 1'b1, 1'b0, 32'd0);
      wait_idle(n_s);
      chk("busy_len_b2b", 32'(n_s), 32'd34);

      // Reset at RUN count 10 aborts without a result
      issue(1'b0, 32'd99, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
      chk("abort_hi", hi, 32'd0);
      chk("abort_lo", lo, 32'd0);
      repeat (40) @(negedge clk);
      run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
